// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped, tagged branch target buffer with one 2-bit saturating counter
// per entry, for a word-addressed 16-bit pipelined CPU.
//
// The IF stage gets a same-cycle prediction for if_pc. The branch-condition
// stage presents each resolved instruction on the upd_* inputs. The block then
// raises mispredict/correct_pc combinationally and trains the table on the
// next rising clock edge.
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-high reset
//   if_pc              PC being fetched
//   pred_taken         the entry for if_pc hits and its counter says taken
//   pred_next_pc       stored target if pred_taken, otherwise if_pc+1
//   upd_valid          a resolved instruction is presented this cycle
//   upd_pc             PC of the resolved instruction
//   upd_is_branch      the instruction is a conditional branch
//   upd_taken          actual branch outcome (0 for non-branches)
//   upd_target         computed branch target
//   upd_pred_taken     prediction carried with the instruction (informational)
//   upd_pred_next_pc   predicted next PC carried with the instruction
//   mispredict         flush request
//   correct_pc         actual next PC, i.e. the refetch address on a flush
//   stat_branches      (BP_STATS_EN only) saturating count of branch updates
//   stat_mispredicts   (BP_STATS_EN only) saturating count of mispredict cycles
//
// Optional feature: define BP_STATS_EN to add the two statistics counters.
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_next_pc,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_is_branch,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_pred_taken,
    input  logic [WORD_SIZE-1:0] upd_pred_next_pc,
    output logic                 mispredict,
    output logic [WORD_SIZE-1:0] correct_pc
`ifdef BP_STATS_EN
    ,
    output logic [WORD_SIZE-1:0] stat_branches,
    output logic [WORD_SIZE-1:0] stat_mispredicts
`endif
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;

    localparam logic [WORD_SIZE-1:0] PC_ONE = WORD_SIZE'(1);

    // Counter encoding: MSB is the predicted direction.
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [TAG_BITS-1:0]  tag;
        logic [WORD_SIZE-1:0] target;
        logic [1:0]           ctr;
    } entry_t;

    entry_t table_q [ENTRIES];

    // ---------------------------------------------------------------- predict
    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0]   if_tag;
    logic                  if_hit;

    assign if_idx = if_pc[INDEX_BITS-1:0];
    assign if_tag = if_pc[WORD_SIZE-1:INDEX_BITS];
    assign if_hit = table_q[if_idx].valid && (table_q[if_idx].tag == if_tag);

    // The table is read before this cycle's update is written, so there is no
    // bypass from upd_* to the prediction.
    assign pred_taken   = if_hit && table_q[if_idx].ctr[1];
    assign pred_next_pc = pred_taken ? table_q[if_idx].target : if_pc + PC_ONE;

    // ---------------------------------------------------------------- resolve
    logic [WORD_SIZE-1:0] actual_next;

    assign actual_next = upd_taken ? upd_target : upd_pc + PC_ONE;
    // Comparing full next PCs also flags a correct direction with a stale target.
    assign mispredict  = upd_valid && (actual_next != upd_pred_next_pc);
    assign correct_pc  = actual_next;

    // The predicted next PC already encodes the predicted direction.
    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken;

    // ----------------------------------------------------------------- update
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0]   upd_tag;
    entry_t                upd_ent;
    logic                  upd_hit;
    entry_t                ent_d;
    logic                  wr_en;

    assign upd_idx = upd_pc[INDEX_BITS-1:0];
    assign upd_tag = upd_pc[WORD_SIZE-1:INDEX_BITS];
    assign upd_ent = table_q[upd_idx];
    assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        wr_en = 1'b0;
        ent_d = upd_ent;
        if (upd_valid) begin
            if (upd_is_branch) begin
                if (upd_hit) begin
                    wr_en = 1'b1;
                    if (upd_taken) begin
                        ent_d.ctr    = (upd_ent.ctr == CTR_ST) ? CTR_ST : upd_ent.ctr + 2'd1;
                        ent_d.target = upd_target;
                    end else begin
                        ent_d.ctr = (upd_ent.ctr == CTR_SNT) ? CTR_SNT : upd_ent.ctr - 2'd1;
                    end
                end else if (upd_taken) begin
                    // Allocate (or replace an aliasing entry) in weak-taken.
                    wr_en        = 1'b1;
                    ent_d.valid  = 1'b1;
                    ent_d.tag    = upd_tag;
                    ent_d.target = upd_target;
                    ent_d.ctr    = CTR_WT;
                end
            end else if (upd_hit) begin
                // A non-branch hitting the BTB is an alias: drop the entry.
                wr_en       = 1'b1;
                ent_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the table is flops, not RAM, and every entry is cleared so
            // nothing is predicted from power-up garbage.
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid  <= 1'b0;
                table_q[i].tag    <= '0;
                table_q[i].target <= '0;
                table_q[i].ctr    <= CTR_WNT;
            end
        end else if (wr_en) begin
            // NOTE: non-blocking so every read in this cycle sees pre-edge state.
            table_q[upd_idx] <= ent_d;
        end
    end

`ifdef BP_STATS_EN
    // ------------------------------------------------------------- statistics
    logic [WORD_SIZE-1:0] stat_branches_q;
    logic [WORD_SIZE-1:0] stat_mispredicts_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (upd_valid && upd_is_branch && (stat_branches_q != '1)) begin
                stat_branches_q <= stat_branches_q + PC_ONE;
            end
            if (mispredict && (stat_mispredicts_q != '1)) begin
                stat_mispredicts_q <= stat_mispredicts_q + PC_ONE;
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor: a directed vector table, hand-
// written reset sequences, then randomized traffic checked against a
// behavioural BTB model. The model is an associative array keyed by index,
// where a missing key means the entry is invalid.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] if_pc;
    logic         pred_taken;
    logic [W-1:0] pred_next_pc;
    logic         upd_valid;
    logic [W-1:0] upd_pc;
    logic         upd_is_branch;
    logic         upd_taken;
    logic [W-1:0] upd_target;
    logic         upd_pred_taken;
    logic [W-1:0] upd_pred_next_pc;
    logic         mispredict;
    logic [W-1:0] correct_pc;
`ifdef BP_STATS_EN
    logic [W-1:0] stat_branches;
    logic [W-1:0] stat_mispredicts;
`endif

    branch_predictor #(.WORD_SIZE(W), .INDEX_BITS(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_next_pc     (pred_next_pc),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_is_branch    (upd_is_branch),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_next_pc (upd_pred_next_pc),
        .mispredict       (mispredict),
        .correct_pc       (correct_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------ model
    typedef struct {
        int tag;
        int target;
        int strength;   // 0..3, taken when >= 2
    } m_ent_t;

    m_ent_t m_btb [int];
    int     m_branches;
    int     m_mispredicts;

    function automatic void m_reset();
        m_btb.delete();
        m_branches    = 0;
        m_mispredicts = 0;
    endfunction

    function automatic bit m_hit(int pc);
        return m_btb.exists(pc % 16) && (m_btb[pc % 16].tag == pc / 16);
    endfunction

    function automatic bit m_taken(int pc);
        return m_hit(pc) && (m_btb[pc % 16].strength >= 2);
    endfunction

    function automatic int m_next(int pc);
        return m_taken(pc) ? m_btb[pc % 16].target : (pc + 1) % 65536;
    endfunction

    function automatic int m_actual(int pc, bit taken, int tgt);
        return taken ? tgt : (pc + 1) % 65536;
    endfunction

    function automatic void m_update(bit uv, int pc, bit br, bit tk, int tgt, int pnp);
        int     idx;
        m_ent_t e;
        if (!uv) return;
        idx = pc % 16;
        if (br && m_branches < 65535) m_branches++;
        if (m_actual(pc, tk, tgt) != pnp && m_mispredicts < 65535) m_mispredicts++;
        if (br) begin
            if (m_hit(pc)) begin
                e = m_btb[idx];
                if (tk) begin
                    e.strength = (e.strength == 3) ? 3 : e.strength + 1;
                    e.target   = tgt;
                end else begin
                    e.strength = (e.strength == 0) ? 0 : e.strength - 1;
                end
                m_btb[idx] = e;
            end else if (tk) begin
                e.tag      = pc / 16;
                e.target   = tgt;
                e.strength = 2;
                m_btb[idx] = e;
            end
        end else if (m_hit(pc)) begin
            m_btb.delete(idx);
        end
    endfunction

    // -------------------------------------------------------------- stimulus
    task automatic drive(input logic [W-1:0] ipc, input logic uv, input logic [W-1:0] upc,
                         input logic br, input logic tk, input logic [W-1:0] tgt,
                         input logic [W-1:0] pnp);
        if_pc            = ipc;
        upd_valid        = uv;
        upd_pc           = upc;
        upd_is_branch    = br;
        upd_taken        = tk;
        upd_target       = tgt;
        upd_pred_next_pc = pnp;
        upd_pred_taken   = (pnp != upc + 16'd1);
    endtask

    typedef struct {
        logic [W-1:0] if_pc;
        logic         uv;
        logic [W-1:0] upc;
        logic         br;
        logic         tk;
        logic [W-1:0] tgt;
        logic [W-1:0] pnp;
        logic         e_pt;
        logic [W-1:0] e_pnp;
        logic         e_mp;
        logic [W-1:0] e_cpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [W-1:0] ipc, logic uv, logic [W-1:0] upc, logic br,
                                logic tk, logic [W-1:0] tgt, logic [W-1:0] pnp,
                                logic e_pt, logic [W-1:0] e_pnp, logic e_mp,
                                logic [W-1:0] e_cpc);
        vec_t v;
        v.if_pc = ipc; v.uv = uv; v.upc = upc; v.br = br; v.tk = tk; v.tgt = tgt;
        v.pnp = pnp; v.e_pt = e_pt; v.e_pnp = e_pnp; v.e_mp = e_mp; v.e_cpc = e_cpc;
        return v;
    endfunction

    initial begin
        //               if_pc  uv upc    br tk tgt    pnp     pt pnp    mp cpc
        vecs.push_back(mk('h0010,0,'h0010,0,0,'h0000,'h0011, 0,'h0011,0,'h0011)); // idle after reset
        vecs.push_back(mk('h0010,1,'h0010,1,1,'h0020,'h0011, 0,'h0011,1,'h0020)); // alloc, ctr=10
        vecs.push_back(mk('h0010,0,'h0010,0,0,'h0000,'h0011, 1,'h0020,0,'h0011)); // now predicts T
        vecs.push_back(mk('h0010,1,'h0010,1,0,'h0000,'h0020, 1,'h0020,1,'h0011)); // 10->01
        vecs.push_back(mk('h0010,1,'h0010,1,0,'h0000,'h0011, 0,'h0011,0,'h0011)); // 01->00
        vecs.push_back(mk('h0010,1,'h0010,1,0,'h0000,'h0011, 0,'h0011,0,'h0011)); // 00 stays
        vecs.push_back(mk('h0010,1,'h0010,1,1,'h0020,'h0011, 0,'h0011,1,'h0020)); // 00->01
        vecs.push_back(mk('h0010,0,'h0010,0,0,'h0000,'h0011, 0,'h0011,0,'h0011)); // 01 still NT
        vecs.push_back(mk('h0010,1,'h0010,1,1,'h0020,'h0011, 0,'h0011,1,'h0020)); // 01->10
        vecs.push_back(mk('h0010,0,'h0010,0,0,'h0000,'h0011, 1,'h0020,0,'h0011));
        vecs.push_back(mk('h0010,1,'h0010,1,1,'h0030,'h0020, 1,'h0020,1,'h0030)); // wrong target
        vecs.push_back(mk('h0010,0,'h0010,0,0,'h0000,'h0011, 1,'h0030,0,'h0011)); // target now 30
        vecs.push_back(mk('h0010,1,'h0010,1,1,'h0030,'h0030, 1,'h0030,0,'h0030)); // 11 stays
        vecs.push_back(mk('h0010,1,'h0010,1,0,'h0000,'h0030, 1,'h0030,1,'h0011)); // 11->10
        vecs.push_back(mk('h0010,0,'h0010,0,0,'h0000,'h0011, 1,'h0030,0,'h0011));
        vecs.push_back(mk('h0010,1,'h0110,1,1,'h0200,'h0111, 1,'h0030,1,'h0200)); // alias replace
        vecs.push_back(mk('h0010,0,'h0010,0,0,'h0000,'h0011, 0,'h0011,0,'h0011)); // old tag misses
        vecs.push_back(mk('h0110,0,'h0010,0,0,'h0000,'h0011, 1,'h0200,0,'h0011));
        vecs.push_back(mk('h0110,1,'h0110,0,0,'h0000,'h0200, 1,'h0200,1,'h0111)); // non-branch hit
        vecs.push_back(mk('h0110,0,'h0010,0,0,'h0000,'h0011, 0,'h0111,0,'h0011)); // invalidated
        vecs.push_back(mk('hFFFF,0,'hFFFF,0,0,'h0000,'h0000, 0,'h0000,0,'h0000)); // wrap
        vecs.push_back(mk('h0110,1,'h0110,0,0,'h0000,'h0111, 0,'h0111,0,'h0111)); // non-branch miss
        vecs.push_back(mk('h0020,1,'h0020,1,0,'h0000,'h0021, 0,'h0021,0,'h0021)); // NT miss: no alloc
        vecs.push_back(mk('h0020,0,'h0020,1,1,'h0040,'h0021, 0,'h0021,0,'h0040)); // uv=0 ignored
        vecs.push_back(mk('h0020,0,'h0020,0,0,'h0000,'h0021, 0,'h0021,0,'h0021));
    end

    // --------------------------------------------------------------- sequence
    initial begin
        reset = 1'b1;
        drive('h0010, 0, 'h0010, 0, 0, 'h0000, 'h0011);
        m_reset();
        #1;
        check("reset_pred_taken", pred_taken, 0);
        check("reset_pred_next_pc", pred_next_pc, 'h0011);
        check("reset_mispredict", mispredict, 0);
        check("reset_correct_pc", correct_pc, 'h0011);
        @(negedge clk);
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].if_pc, vecs[i].uv, vecs[i].upc, vecs[i].br, vecs[i].tk,
                  vecs[i].tgt, vecs[i].pnp);
            #1;
            check($sformatf("vec%0d_pred_taken", i), pred_taken, vecs[i].e_pt);
            check($sformatf("vec%0d_pred_next_pc", i), pred_next_pc, vecs[i].e_pnp);
            check($sformatf("vec%0d_mispredict", i), mispredict, vecs[i].e_mp);
            check($sformatf("vec%0d_correct_pc", i), correct_pc, vecs[i].e_cpc);
            m_update(vecs[i].uv, vecs[i].upc, vecs[i].br, vecs[i].tk, vecs[i].tgt, vecs[i].pnp);
        end

        // Train 0x0005 -> 0x0050, then assert reset between edges.
        @(negedge clk);
        drive('h0005, 1, 'h0005, 1, 1, 'h0050, 'h0006);
        m_update(1, 'h0005, 1, 1, 'h0050, 'h0006);
        @(negedge clk);
        drive('h0005, 0, 'h0005, 0, 0, 'h0000, 'h0006);
        #1;
        check("trained_pred_taken", pred_taken, 1);
        check("trained_pred_next_pc", pred_next_pc, 'h0050);
`ifdef BP_STATS_EN
        check("stat_branches_count", stat_branches, m_branches);
        check("stat_mispredicts_count", stat_mispredicts, m_mispredicts);
`endif
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        check("async_reset_pred_taken", pred_taken, 0);
        check("async_reset_pred_next_pc", pred_next_pc, 'h0006);
`ifdef BP_STATS_EN
        check("async_reset_stat_branches", stat_branches, 0);
        check("async_reset_stat_mispredicts", stat_mispredicts, 0);
`endif

        // An update presented across an edge while reset is held is dropped.
        @(negedge clk);
        drive('h0007, 1, 'h0007, 1, 1, 'h0070, 'h0008);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive('h0007, 0, 'h0007, 0, 0, 'h0000, 'h0008);
        #1;
        check("reset_edge_update_dropped", pred_taken, 0);
        check("reset_edge_next_pc", pred_next_pc, 'h0008);

        // Randomized traffic against the model. A small PC pool forces hits and aliases.
        for (int n = 0; n < 600; n++) begin
            logic [W-1:0] ipc, upc, tgt, pnp;
            logic         uv, br, tk;
            @(negedge clk);
            ipc = ($urandom_range(0, 19) == 0) ? 16'hFFFF
                  : W'($urandom_range(0, 2) * 16 + $urandom_range(0, 3));
            upc = ($urandom_range(0, 19) == 0) ? 16'hFFFF
                  : W'($urandom_range(0, 2) * 16 + $urandom_range(0, 3));
            uv  = ($urandom_range(0, 4) != 0);
            br  = ($urandom_range(0, 3) != 0);
            tk  = br ? 1'($urandom_range(0, 1)) : 1'b0;
            tgt = W'($urandom_range(0, 3) * 'h100);
            pnp = ($urandom_range(0, 2) != 0) ? W'(m_next(int'(upc))) : W'($urandom_range(0, 65535));
            drive(ipc, uv, upc, br, tk, tgt, pnp);
            #1;
            check($sformatf("rnd%0d_pred_taken", n), pred_taken, m_taken(int'(ipc)));
            check($sformatf("rnd%0d_pred_next_pc", n), pred_next_pc, m_next(int'(ipc)));
            check($sformatf("rnd%0d_mispredict", n), mispredict,
                  uv && (m_actual(int'(upc), tk, int'(tgt)) != int'(pnp)));
            check($sformatf("rnd%0d_correct_pc", n), correct_pc, m_actual(int'(upc), tk, int'(tgt)));
            m_update(uv, int'(upc), br, tk, int'(tgt), int'(pnp));
        end

`ifdef BP_STATS_EN
        @(negedge clk);
        drive('h0000, 0, 'h0000, 0, 0, 'h0000, 'h0001);
        #1;
        check("rnd_stat_branches", stat_branches, m_branches);
        check("rnd_stat_mispredicts", stat_mispredicts, m_mispredicts);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
